// File: rtl/lock_pkg.sv
// Shared constants, state type and glyph lookup for the lock front-end.
package lock_pkg;

  localparam int DEF_NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic {S_ENTRY, S_DONE} state_t;

  // Active-low a..g glyph for a BCD digit; non-decimal values show a dash.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0000100;
      default: glyph = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/button_cond.sv
// Raw push-button conditioning: 2-flop synchroniser, debounce counter,
// rising-edge detect giving a single-cycle press pulse.
module button_cond #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/digit_entry.sv
// Six-digit BCD code entry with per-digit glyph writes to the display bank.
// Optional DIGIT_ENTRY_MASK_EN: dash out the previously entered digit.
//
// state   | meaning
// S_ENTRY | collecting digits, pos = next slot to fill
// S_DONE  | code complete and held until restart or clear
module digit_entry import lock_pkg::*; #(
  parameter int NUM_DIGITS      = DEF_NUM_DIGITS,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int IDLE_TIMEOUT    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    restart,
  input  logic [3:0]              digit_in,
  input  logic                    btn_enter,
  input  logic                    btn_back,
  input  logic                    btn_clear,
  output logic [0:6]              seg_out,
  output logic [2:0]              seg_pos,
  output logic                    seg_we,
  output logic                    clr_disp,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] code,
  output logic                    digit_err
`ifdef DIGIT_ENTRY_MASK_EN
  ,
  output logic                    seg_we_prev,
  output logic [2:0]              seg_pos_prev
`endif
);

  logic w_p_enter, w_p_back, w_p_clear;

  button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_enter), .o_press(w_p_enter));
  button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_back), .o_press(w_p_back));
  button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_clear), .o_press(w_p_clear));

  state_t                  r_state, w_state_nxt;
  logic [2:0]              r_pos, w_pos_nxt;
  logic [4*NUM_DIGITS-1:0] r_code, w_code_nxt;
  logic [6:0]              r_seg_out, w_seg_out_nxt;
  logic [2:0]              r_seg_pos, w_seg_pos_nxt;
  logic                    r_seg_we, w_seg_we_nxt;
  logic                    r_clr, w_clr_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_err, w_err_nxt;
`ifdef DIGIT_ENTRY_MASK_EN
  logic                    r_we_prev, w_we_prev_nxt;
  logic [2:0]              r_pos_prev, w_pos_prev_nxt;
`endif

  logic       w_timeout;
  logic       w_act_clr, w_act_back, w_act_enter;
  logic       w_digit_bad, w_last;
  logic [2:0] w_pos_m1;

  // Only the highest-priority request acts: restart/clear/timeout > back > enter.
  assign w_act_clr   = restart | w_p_clear | w_timeout;
  assign w_act_back  = ~w_act_clr & w_p_back;
  assign w_act_enter = ~w_act_clr & ~w_p_back & w_p_enter;
  assign w_digit_bad = digit_in > 4'd9;
  assign w_last      = r_pos == 3'(NUM_DIGITS - 1);
  assign w_pos_m1    = r_pos - 3'd1;

  generate
    if (IDLE_TIMEOUT > 0) begin : g_idle
      localparam int IW = $clog2(IDLE_TIMEOUT + 1);
      logic [IW-1:0] r_idle_cnt;
      logic          w_any_press;

      assign w_any_press = restart | w_p_enter | w_p_back | w_p_clear;
      assign w_timeout   = (r_state == S_ENTRY) && (r_pos != 3'd0) &&
                           !w_any_press && (r_idle_cnt == '0);

      always_ff @(posedge clk) begin
        if (!rst_n || w_any_press || w_timeout || r_state != S_ENTRY || r_pos == 3'd0)
          r_idle_cnt <= IW'(IDLE_TIMEOUT - 1);
        else
          r_idle_cnt <= r_idle_cnt - IW'(1);
      end
    end else begin : g_no_idle
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_ENTRY;
      r_pos     <= '0;
      r_code    <= '0;
      r_seg_out <= SEG_BLANK;
      r_seg_pos <= '0;
      r_seg_we  <= 1'b0;
      r_clr     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef DIGIT_ENTRY_MASK_EN
      r_we_prev  <= 1'b0;
      r_pos_prev <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_pos     <= w_pos_nxt;
      r_code    <= w_code_nxt;
      r_seg_out <= w_seg_out_nxt;
      r_seg_pos <= w_seg_pos_nxt;
      r_seg_we  <= w_seg_we_nxt;
      r_clr     <= w_clr_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
`ifdef DIGIT_ENTRY_MASK_EN
      r_we_prev  <= w_we_prev_nxt;
      r_pos_prev <= w_pos_prev_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_code_nxt  = r_code;
    if (w_act_clr) begin
      w_state_nxt = S_ENTRY;
      w_pos_nxt   = '0;
      w_code_nxt  = '0;
    end else if (r_state == S_ENTRY) begin
      if (w_act_back) begin
        if (r_pos != 3'd0) begin
          w_pos_nxt = w_pos_m1;
          for (int i = 0; i < NUM_DIGITS; i++)
            if (3'(i) == w_pos_m1) w_code_nxt[4*i +: 4] = 4'd0;
        end
      end else if (w_act_enter && !w_digit_bad) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (3'(i) == r_pos) w_code_nxt[4*i +: 4] = digit_in;
        if (w_last) w_state_nxt = S_DONE;
        else        w_pos_nxt   = r_pos + 3'd1;
      end
    end
  end

  always_comb begin
    w_seg_out_nxt = r_seg_out;
    w_seg_pos_nxt = r_seg_pos;
    w_seg_we_nxt  = 1'b0;
    w_clr_nxt     = 1'b0;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
`ifdef DIGIT_ENTRY_MASK_EN
    // The final digit is masked the cycle after done.
    w_we_prev_nxt  = r_done;
    w_pos_prev_nxt = r_done ? 3'(NUM_DIGITS - 1) : r_pos_prev;
`endif
    if (w_act_clr) begin
      w_clr_nxt = 1'b1;
    end else if (r_state == S_ENTRY) begin
      if (w_act_back) begin
        if (r_pos != 3'd0) begin
          w_seg_out_nxt = SEG_BLANK;
          w_seg_pos_nxt = w_pos_m1;
          w_seg_we_nxt  = 1'b1;
        end
      end else if (w_act_enter) begin
        if (w_digit_bad) begin
          w_err_nxt = 1'b1;
        end else begin
          w_seg_out_nxt = glyph(digit_in);
          w_seg_pos_nxt = r_pos;
          w_seg_we_nxt  = 1'b1;
          w_done_nxt    = w_last;
`ifdef DIGIT_ENTRY_MASK_EN
          if (r_pos != 3'd0) begin
            w_we_prev_nxt  = 1'b1;
            w_pos_prev_nxt = w_pos_m1;
          end
`endif
        end
      end
    end
  end

  assign seg_out   = r_seg_out;
  assign seg_pos   = r_seg_pos;
  assign seg_we    = r_seg_we;
  assign clr_disp  = r_clr;
  assign done      = r_done;
  assign code      = r_code;
  assign digit_err = r_err;
`ifdef DIGIT_ENTRY_MASK_EN
  assign seg_we_prev  = r_we_prev;
  assign seg_pos_prev = r_pos_prev;
`endif

endmodule
